rvfi_retire_checker: RTL

Consumer side of the core's RVFI retirement port: a synthesizable monitor that takes each retired-instruction packet from `myRiscv` and checks it for internal consistency. It keeps a shadow register file, order and PC continuity state, and a halt state. Any violation is reported as a sticky, registered error with a code and the offending `rvfi_order`. It sits beside the core inside the formal wrapper and in simulation benches, and drives nothing back into the core.

---
 rtl/rvfi_chk_pkg.sv | 19 +
 rtl/rvfi_shadow_regfile.sv | 37 +++
 rtl/rvfi_retire_checker.sv | 124 ++++++++++++
 3 files changed

// File: rtl/rvfi_chk_pkg.sv
// rvfi_chk_pkg: shared types and mask legality helper for the RVFI retirement checker
package rvfi_chk_pkg;
  typedef enum logic [1:0] {ST_FIRST, ST_RUN, ST_HALTED, ST_ERROR} state_t;
  typedef enum logic [3:0] {
    E_NONE       = 4'd0,
    E_ORDER      = 4'd1,
    E_PC         = 4'd2,
    E_X0_READ    = 4'd3,
    E_RS1        = 4'd4,
    E_RS2        = 4'd5,
    E_X0_WRITE   = 4'd6,
    E_MEM_MASK   = 4'd7,
    E_PC_ALIGN   = 4'd8,
    E_AFTER_HALT = 4'd9
  } err_code_t;
  function automatic logic mask_legal(input logic [3:0] m);
    return m inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
  endfunction
endpackage

// File: rtl/rvfi_shadow_regfile.sv
// rvfi_shadow_regfile: x1..x31 shadow storage with known bits, two async read ports, one write port
module rvfi_shadow_regfile #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [4:0]   ra1,
  input  logic [4:0]   ra2,
  output logic [W-1:0] rd1,
  output logic [W-1:0] rd2,
  output logic         kn1,
  output logic         kn2,
  input  logic         we,
  input  logic [4:0]   wa,
  input  logic [W-1:0] wd
);
  logic [W-1:0] data_q [32];
  logic [W-1:0] data_d [32];
  logic [31:0]  known_q, known_d;
  always_comb begin
    data_d  = data_q;
    known_d = known_q;
    if (we && wa != 5'd0) begin
      data_d[wa]  = wd;
      known_d[wa] = 1'b1;
    end
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) known_q <= '0;
    else known_q <= known_d;
  // data needs no reset: entries are ignored until their known bit is set
  always_ff @(posedge clock) data_q <= data_d;
  assign rd1 = data_q[ra1];
  assign rd2 = data_q[ra2];
  assign kn1 = known_q[ra1];
  assign kn2 = known_q[ra2];
endmodule

// File: rtl/rvfi_retire_checker.sv
// rvfi_retire_checker: consistency monitor for RVFI retirement packets with sticky registered error reporting
module rvfi_retire_checker
  import rvfi_chk_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit CHECK_PC  = 1'b1,
  parameter bit CHECK_MEM = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            rvfi_valid,
  input  logic [63:0]     rvfi_order,
  input  logic [31:0]     rvfi_insn,
  input  logic            rvfi_trap,
  input  logic            rvfi_halt,
  input  logic            rvfi_intr,
  input  logic [4:0]      rvfi_rs1_addr,
  input  logic [4:0]      rvfi_rs2_addr,
  input  logic [4:0]      rvfi_rd_addr,
  input  logic [XLEN-1:0] rvfi_rs1_rdata,
  input  logic [XLEN-1:0] rvfi_rs2_rdata,
  input  logic [XLEN-1:0] rvfi_rd_wdata,
  input  logic [XLEN-1:0] rvfi_pc_rdata,
  input  logic [XLEN-1:0] rvfi_pc_wdata,
  input  logic [XLEN-1:0] rvfi_mem_addr,
  input  logic [XLEN-1:0] rvfi_mem_rdata,
  input  logic [XLEN-1:0] rvfi_mem_wdata,
  input  logic [3:0]      rvfi_mem_rmask,
  input  logic [3:0]      rvfi_mem_wmask,
  output logic            err,
  output logic [3:0]      err_code,
  output logic [63:0]     err_order,
  output logic [31:0]     retired_count,
  output logic            halted
);
  state_t          state_q, state_d;
  err_code_t       err_code_q, err_code_d, code;
  logic            err_q, err_d, halted_q, halted_d, accept;
  logic [63:0]     err_order_q, err_order_d, prev_order_q, prev_order_d;
  logic [31:0]     count_q, count_d;
  logic [XLEN-1:0] prev_pc_q, prev_pc_d, sh1, sh2;
  logic            kn1, kn2;
  logic            ord_bad, pc_bad, x0r_bad, rs1_bad, rs2_bad, x0w_bad, mem_bad, align_bad;
  logic            unused_ok;
  assign unused_ok = ^{rvfi_insn, rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata};
  rvfi_shadow_regfile #(.W(XLEN)) u_shadow (
    .clock(clock), .reset(reset),
    .ra1(rvfi_rs1_addr), .ra2(rvfi_rs2_addr),
    .rd1(sh1), .rd2(sh2), .kn1(kn1), .kn2(kn2),
    .we(accept && !rvfi_trap), .wa(rvfi_rd_addr), .wd(rvfi_rd_wdata)
  );
  // trapped packets are only held to order, PC continuity and PC alignment
  always_comb begin
    ord_bad   = (state_q == ST_FIRST) ? (rvfi_order != 64'd0) : (rvfi_order != prev_order_q + 64'd1);
    pc_bad    = CHECK_PC && !rvfi_intr && state_q != ST_FIRST && rvfi_pc_rdata != prev_pc_q;
    x0r_bad   = !rvfi_trap && ((rvfi_rs1_addr == 5'd0 && rvfi_rs1_rdata != '0) ||
                               (rvfi_rs2_addr == 5'd0 && rvfi_rs2_rdata != '0));
    rs1_bad   = !rvfi_trap && rvfi_rs1_addr != 5'd0 && kn1 && rvfi_rs1_rdata != sh1;
    rs2_bad   = !rvfi_trap && rvfi_rs2_addr != 5'd0 && kn2 && rvfi_rs2_rdata != sh2;
    x0w_bad   = !rvfi_trap && rvfi_rd_addr == 5'd0 && rvfi_rd_wdata != '0;
    mem_bad   = CHECK_MEM && !rvfi_trap && !(mask_legal(rvfi_mem_rmask) && mask_legal(rvfi_mem_wmask));
    align_bad = CHECK_PC && rvfi_pc_wdata[1:0] != 2'b00;
    code = ord_bad   ? E_ORDER    :
           pc_bad    ? E_PC       :
           x0r_bad   ? E_X0_READ  :
           rs1_bad   ? E_RS1      :
           rs2_bad   ? E_RS2      :
           x0w_bad   ? E_X0_WRITE :
           mem_bad   ? E_MEM_MASK :
           align_bad ? E_PC_ALIGN :
           (state_q == ST_HALTED) ? E_AFTER_HALT : E_NONE;
  end
  always_comb begin
    state_d      = state_q;
    err_d        = err_q;
    err_code_d   = err_code_q;
    err_order_d  = err_order_q;
    prev_order_d = prev_order_q;
    prev_pc_d    = prev_pc_q;
    count_d      = count_q;
    halted_d     = halted_q;
    accept       = 1'b0;
    if (rvfi_valid && state_q != ST_ERROR) begin
      if (code != E_NONE) begin
        state_d     = ST_ERROR;
        err_d       = 1'b1;
        err_code_d  = code;
        err_order_d = rvfi_order;
      end else begin
        accept       = 1'b1;
        state_d      = rvfi_halt ? ST_HALTED : ST_RUN;
        prev_order_d = rvfi_order;
        prev_pc_d    = rvfi_pc_wdata;
        count_d      = (count_q == 32'hFFFF_FFFF) ? count_q : count_q + 32'd1;
        halted_d     = halted_q | rvfi_halt;
      end
    end
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_q      <= ST_FIRST;
      err_q        <= 1'b0;
      err_code_q   <= E_NONE;
      err_order_q  <= '0;
      prev_order_q <= '0;
      prev_pc_q    <= '0;
      count_q      <= '0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
      err_order_q  <= err_order_d;
      prev_order_q <= prev_order_d;
      prev_pc_q    <= prev_pc_d;
      count_q      <= count_d;
      halted_q     <= halted_d;
    end
  assign err           = err_q;
  assign err_code      = err_code_q;
  assign err_order     = err_order_q;
  assign retired_count = count_q;
  assign halted        = halted_q;
endmodule
